// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO read-side streamer.
package fifo_pkg;

  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_BUFDEPTH  = 2;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  function automatic logic [1:0] occ_count(input occ_t occ);
    logic [1:0] cnt;
    case (occ)
      OCC_EMPTY: cnt = 2'd0;
      OCC_ONE:   cnt = 2'd1;
      OCC_TWO:   cnt = 2'd2;
      default:   cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/fifo_read_streamer_skid_buf.sv
// Two-entry register buffer; the head entry always drives the output data.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] head_data,
  output logic                 valid,
  output occ_t                 occ,
  output logic                 full
);

  occ_t                 occ_r;
  logic [DATAWIDTH-1:0] head_r;
  logic [DATAWIDTH-1:0] tail_r;
  logic                 valid_r;

  // occupancy FSM with the head/tail storage and the registered valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r   <= OCC_EMPTY;
      head_r  <= '0;
      tail_r  <= '0;
      valid_r <= 1'b0;
    end else if (clear) begin
      occ_r   <= OCC_EMPTY;
      valid_r <= 1'b0;
    end else begin
      case (occ_r)
        OCC_EMPTY: begin
          if (push) begin
            head_r  <= push_data;
            occ_r   <= OCC_ONE;
            valid_r <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_r <= push_data;
          end else if (push) begin
            tail_r <= push_data;
            occ_r  <= OCC_TWO;
          end else if (pop) begin
            occ_r   <= OCC_EMPTY;
            valid_r <= 1'b0;
          end
        end
        OCC_TWO: begin
          // the tail moves up on a pop; a simultaneous push refills the tail
          if (pop) begin
            head_r <= tail_r;
            if (push) begin
              tail_r <= push_data;
            end else begin
              occ_r <= OCC_ONE;
            end
          end
        end
        default: begin
          occ_r   <= OCC_EMPTY;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign head_data = head_r;
  assign valid     = valid_r;
  assign occ       = occ_r;
  assign full      = (occ_r == OCC_TWO);

endmodule

// File: rtl/fifo_read_streamer.sv
// FIFO read-side streamer: issues R_En, absorbs the read latency, emits valid/ready.
// Optional word counter on rd_count when READ_STREAM_COUNT_EN is defined.
module fifo_read_streamer
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int BUFDEPTH  = DEF_BUFDEPTH
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 Empty,
  input  logic [DATAWIDTH-1:0] R_Data,
  output logic                 R_En,
  input  logic                 flush,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready
`ifdef READ_STREAM_COUNT_EN
  ,
  output logic [CNT_W-1:0]     rd_count
`endif
);

  localparam logic [2:0] DEPTH_C = 3'(BUFDEPTH);

  logic       inflight_r;
  logic       pop_s;
  logic       push_s;
  logic       full_s;
  logic       rd_en_s;
  logic [2:0] level_s;
  occ_t       occ_s;

  assign pop_s   = m_valid & m_ready;
  assign push_s  = inflight_r & ~flush;
  assign level_s = {1'b0, occ_count(occ_s)} + {2'b00, inflight_r};

  // a full buffer only has room when the head leaves this cycle and nothing is in flight
  assign rd_en_s = rrst & ~Empty & ~flush &
                   (full_s ? (pop_s & ~inflight_r)
                           : ((level_s - {2'b00, pop_s}) < DEPTH_C));
  assign R_En    = rd_en_s;

  // tracks the word whose read data arrives on the next edge
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
    end
  end

  stream_skid_buf #(
    .DATAWIDTH (DATAWIDTH)
  ) u_buf (
    .clk       (rclk),
    .rst_n     (rrst),
    .clear     (flush),
    .push      (push_s),
    .push_data (R_Data),
    .pop       (pop_s),
    .head_data (m_data),
    .valid     (m_valid),
    .occ       (occ_s),
    .full      (full_s)
  );

`ifdef READ_STREAM_COUNT_EN
  logic [CNT_W-1:0] cnt_r;

  // delivered-word counter; survives flush and wraps naturally
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      cnt_r <= '0;
    end else if (pop_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign rd_count = cnt_r;
`endif

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Self-checking bench for fifo_read_streamer with a behavioural FIFO and a scoreboard.
module tb_fifo_read_streamer;

  localparam int DW = 32;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          Empty;
  logic [DW-1:0] R_Data;
  logic          R_En;
  logic          flush;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
`ifdef READ_STREAM_COUNT_EN
  logic [15:0]   rd_count;
`endif

  always #5 rclk = ~rclk;

  fifo_read_streamer #(
    .DATAWIDTH (DW),
    .BUFDEPTH  (2)
  ) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .Empty   (Empty),
    .R_Data  (R_Data),
    .R_En    (R_En),
    .flush   (flush),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
`ifdef READ_STREAM_COUNT_EN
    ,
    .rd_count(rd_count)
`endif
  );

  typedef struct {
    logic          rst;
    logic          ld;
    logic [DW-1:0] word;
    logic          rdy;
    logic          fl;
    logic          exp_ren;
    logic          exp_mv;
  } vec_t;

  int            errors = 0;
  int            checks = 0;
  int            delivered = 0;
  int            ren_pulses = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          last_mv = 1'b0;
  logic [DW-1:0] last_md = '0;
  vec_t          tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    Empty = 1'b0;
  endtask

  // One clock: sample outputs, score transfers, then model the FIFO read port.
  task automatic step();
    logic          ren;
    logic [DW-1:0] md;
    #1;
    ren     = R_En;
    last_mv = m_valid;
    md      = m_data;
    last_md = md;
    if (ren) ren_pulses++;
    chk("r_en_while_empty", {63'd0, ren & Empty}, 64'd0);
    if (prev_stall) begin
      chk("stall_hold_valid", {63'd0, last_mv}, 64'd1);
      chk("stall_hold_data", {32'd0, md}, {32'd0, prev_data});
    end
    if (last_mv && m_ready && rrst) begin
      delivered++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_word: got %0h expected no word", md);
      end else begin
        chk("sb_word", {32'd0, md}, {32'd0, exp_q.pop_front()});
      end
    end
    if (flush) exp_q.delete();
    prev_stall = last_mv & ~m_ready & ~flush & rrst;
    prev_data  = md;
    @(posedge rclk);
    #1;
    if (ren && fifo_q.size() > 0) begin
      R_Data = fifo_q.pop_front();
      exp_q.push_back(R_Data);
    end
    Empty = (fifo_q.size() == 0);
  endtask

  initial begin
    int            run;
    int            first;
    int            last;
    int            nmv;
    int            k;
    logic [DW-1:0] head;

    rrst = 1'b1; Empty = 1'b1; R_Data = '0; flush = 1'b0; m_ready = 1'b0;
    #1 rrst = 1'b0;
    @(posedge rclk);
    #1;

    // reset, release, single word
    tbl[0] = '{1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rrst = tbl[i].rst; m_ready = tbl[i].rdy; flush = tbl[i].fl;
      if (tbl[i].ld) load(tbl[i].word);
      #1;
      chk($sformatf("tbl%0d_r_en", i), {63'd0, R_En}, {63'd0, tbl[i].exp_ren});
      chk($sformatf("tbl%0d_m_valid", i), {63'd0, m_valid}, {63'd0, tbl[i].exp_mv});
      if (i == 0) chk("reset_m_data", {32'd0, m_data}, 64'd0);
      if (tbl[i].exp_mv) chk("single_word_data", {32'd0, m_data}, 64'hA5A5A5A5);
      step();
    end

    // backpressure: five words, sink stalled
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(32'h1000_0001 + i);
    ren_pulses = 0;
    repeat (8) step();
    chk("bp_ren_pulses", ren_pulses, 2);
    #1;
    chk("bp_ren_low", {63'd0, R_En}, 64'd0);
    chk("bp_head_data", {32'd0, m_data}, 64'h1000_0001);
    m_ready = 1'b1;
    run = 0;
    repeat (5) begin step(); if (last_mv) run++; end
    chk("bp_back_to_back", run, 5);
    chk("bp_drained", exp_q.size(), 0);
    step();

    // throughput: 100 words, sink always ready
    for (int i = 0; i < 100; i++) load(32'h2000_0000 + i);
    first = -1; last = -1; nmv = 0;
    for (int c = 0; c < 110; c++) begin
      step();
      if (last_mv) begin
        if (first < 0) first = c;
        last = c;
        nmv++;
      end
    end
    chk("tp_latency", first, 2);
    chk("tp_count", nmv, 100);
    chk("tp_no_bubbles", last - first, 99);
`ifdef READ_STREAM_COUNT_EN
    chk("tp_rd_count", {48'd0, rd_count}, {48'd0, 16'(delivered)});
`endif

    // flush while streaming with a buffered word and one in flight
    for (int i = 0; i < 6; i++) load(32'h3000_0001 + i);
    m_ready = 1'b1;
    repeat (3) step();
    m_ready = 1'b0; flush = 1'b1;
    #1;
    chk("flush_ren_low", {63'd0, R_En}, 64'd0);
    step();
    flush = 1'b0; m_ready = 1'b1;
    head = fifo_q[0];
    #1;
    chk("flush_valid_cleared", {63'd0, m_valid}, 64'd0);
    chk("flush_ren_resume", {63'd0, R_En}, 64'd1);
    k = 0;
    do begin step(); k++; end while (!last_mv && k < 10);
    chk("flush_timeout", {63'd0, last_mv}, 64'd1);
    chk("flush_next_word", {32'd0, last_md}, {32'd0, head});
    repeat (8) step();
`ifdef READ_STREAM_COUNT_EN
    chk("flush_keeps_count", {48'd0, rd_count}, {48'd0, 16'(delivered)});
`endif

    // Empty rises right after the only read
    load(32'h4000_0001);
    ren_pulses = 0;
    step();
    #1;
    chk("race_empty_seen", {63'd0, Empty}, 64'd1);
    chk("race_no_ren", {63'd0, R_En}, 64'd0);
    step();
    step();
    chk("race_word_valid", {63'd0, last_mv}, 64'd1);
    chk("race_word_data", {32'd0, last_md}, 64'h4000_0001);
    repeat (3) step();
    chk("race_single_read", ren_pulses, 1);

    // Empty rises with one word buffered and one in flight, sink stalled
    m_ready = 1'b0;
    load(32'h5000_0001);
    load(32'h5000_0002);
    repeat (4) step();
    m_ready = 1'b1;
    repeat (4) step();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
